// File: rtl/limiter_pkg.sv
// Shared constants and FSM encoding for the peak limiter.
package limiter_pkg;

   localparam int GAIN_W     = 9;
   localparam int GAIN_FRAC  = 8;
   localparam int UNITY_GAIN = 256;
   localparam int GAIN_MIN   = 16;

   typedef enum logic [1:0] {
      IDLE,
      SCALE,
      CLAMP,
      OUTPUT
   } state_t;

endpackage

// File: rtl/limiter_gain_ctrl.sv
// Gain register (Q1.8) with fast multiplicative attack and slow +1 release.
module limiter_gain_ctrl
   import limiter_pkg::*;
#(
   parameter int ATTACK_SHIFT   = 2,
   parameter int RELEASE_PERIOD = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              update,
   input  logic              over,
   output logic [GAIN_W-1:0] gain
);

   localparam int CNT_W = (RELEASE_PERIOD > 1) ? $clog2(RELEASE_PERIOD) : 1;

   logic [CNT_W-1:0]  rel_cnt;
   logic [GAIN_W-1:0] attacked;

   assign attacked = gain - (gain >> ATTACK_SHIFT);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         gain    <= GAIN_W'(UNITY_GAIN);
         rel_cnt <= '0;
      end else if (update) begin
         if (over) begin
            gain    <= (attacked < GAIN_W'(GAIN_MIN)) ? GAIN_W'(GAIN_MIN) : attacked;
            rel_cnt <= '0;
         end else if (rel_cnt == CNT_W'(RELEASE_PERIOD - 1)) begin
            rel_cnt <= '0;
            if (gain < GAIN_W'(UNITY_GAIN))
               gain <= gain + GAIN_W'(1);
         end else begin
            rel_cnt <= rel_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/peak_limiter.sv
// Sample limiter: IDLE -> SCALE (x*gain) -> CLAMP (to +/-threshold) -> OUTPUT.
// Define PEAK_LIMITER_RELEASE_EN for attack/release gain; otherwise gain is fixed unity.
module peak_limiter
   import limiter_pkg::*;
#(
   parameter int WIDTH          = 12,
   parameter int ATTACK_SHIFT   = 2,
   parameter int RELEASE_PERIOD = 64
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] incoming_sample,
   input  logic        [WIDTH-2:0] threshold,
   output logic signed [WIDTH-1:0] limited_sample,
   output logic                    done,
   output logic       [GAIN_W-1:0] gain
);

   localparam int PW = WIDTH + GAIN_W;

   if (ATTACK_SHIFT < 0 || RELEASE_PERIOD < 1 || WIDTH < 2) begin : g_bad_cfg
      $error("peak_limiter: invalid parameter set");
   end

   state_t                  state;
   logic signed [WIDTH-1:0] x_reg;
   logic        [WIDTH-2:0] thr_reg;
   logic signed [WIDTH-1:0] scaled;
   logic signed [PW-1:0]    product;
   logic signed [WIDTH-1:0] scaled_next;
   logic signed [WIDTH:0]   scaled_ext;
   logic        [WIDTH:0]   mag;
   logic signed [WIDTH-1:0] thr_s;
   logic signed [WIDTH-1:0] clamped;
   logic                    over;

   // gain <= unity keeps x*gain>>8 inside WIDTH, so the truncating cast is lossless
   assign product     = $signed({{GAIN_W{x_reg[WIDTH-1]}}, x_reg}) * $signed({{WIDTH{1'b0}}, gain});
   assign scaled_next = WIDTH'(product >>> GAIN_FRAC);

   // one extra bit so the most negative value has a representable magnitude
   assign scaled_ext = {scaled[WIDTH-1], scaled};
   assign mag        = scaled_ext[WIDTH] ? $unsigned(-scaled_ext) : $unsigned(scaled_ext);
   assign over       = mag > {2'b00, thr_reg};
   assign thr_s      = $signed({1'b0, thr_reg});
   assign clamped    = !over ? scaled : (scaled[WIDTH-1] ? -thr_s : thr_s);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         x_reg          <= '0;
         thr_reg        <= '0;
         scaled         <= '0;
         limited_sample <= '0;
         done           <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  x_reg   <= incoming_sample;
                  thr_reg <= threshold;
                  state   <= SCALE;
               end
            end
            SCALE: begin
               scaled <= scaled_next;
               state  <= CLAMP;
            end
            CLAMP: begin
               limited_sample <= clamped;
               done           <= 1'b1;
               state          <= OUTPUT;
            end
            OUTPUT:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PEAK_LIMITER_RELEASE_EN
   logic over_reg;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         over_reg <= 1'b0;
      else if (state == CLAMP)
         over_reg <= over;
   end

   limiter_gain_ctrl #(
      .ATTACK_SHIFT  (ATTACK_SHIFT),
      .RELEASE_PERIOD(RELEASE_PERIOD)
   ) u_gain_ctrl (
      .clock (clock),
      .reset (reset),
      .update(state == OUTPUT),
      .over  (over_reg),
      .gain  (gain)
   );
`else
   assign gain = GAIN_W'(UNITY_GAIN);
`endif

endmodule
